rf_scan_ctrl: RTL and testbench



---
 rtl/rf_scan_ctrl_pkg.sv | 20 ++
 rtl/rf_scan_ctrl_if.sv | 31 +++
 rtl/rf_port_arb.sv | 57 +++++
 rtl/rf_scan_ctrl.sv | 122 ++++++++++++
 tb/tb_rf_scan_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_scan_ctrl_pkg.sv
// rf_scan_pkg: shared definitions for the register-file scan controller.
//   AW_DEF / DW_DEF : default address / data widths (32 x 32-bit registers).
//   state_e         : sequencer state encoding (IDLE, WAIT, REQ).
//   addr_first()    : first address of the scan range (x0 skipped or not).
package rf_scan_pkg;

    localparam int AW_DEF = 5;
    localparam int DW_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_REQ  = 2'd2
    } state_e;

    function automatic int unsigned addr_first(input bit skip_zero);
        return skip_zero ? 32'd1 : 32'd0;
    endfunction

endpackage

// File: rtl/rf_scan_ctrl_if.sv
// rf_scan_ctrl_if: the shared register-file read port plus the CPU-side request.
//   cpu_rd_req  : CPU asks for the read port (level, may stay high).
//   cpu_rd_addr : CPU read address.
//   cpu_rd_gnt  : CPU owns the port this cycle (combinational).
//   rf_raddr    : address presented to the RF read port (combinational).
//   rf_rdata    : RF read data, combinational from rf_raddr.
// Handshake: a CPU read happens in every cycle where cpu_rd_req and cpu_rd_gnt
// are both high; rf_rdata in that cycle belongs to cpu_rd_addr. When req is high
// and gnt low the scanner has the port and the CPU must retry next cycle.
interface rf_scan_ctrl_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          cpu_rd_req;
    logic [AW-1:0] cpu_rd_addr;
    logic          cpu_rd_gnt;
    logic [AW-1:0] rf_raddr;
    logic [DW-1:0] rf_rdata;

    // Requester / register-file side.
    modport master (
        output cpu_rd_req, cpu_rd_addr, rf_rdata,
        input  cpu_rd_gnt, rf_raddr
    );

    // Scan controller side.
    modport slave (
        input  cpu_rd_req, cpu_rd_addr, rf_rdata,
        output cpu_rd_gnt, rf_raddr
    );
endinterface

// File: rtl/rf_port_arb.sv
// rf_port_arb: arbitrates the single RF read port between the CPU and the scanner.
//   clk, rstn     : clock, synchronous active-low reset.
//   scan_req_i    : scanner is requesting (controller in REQ).
//   capture_i     : scanner read is being captured this cycle.
//   cpu_rd_req_i  : CPU request.
//   scan_addr_i   : scanner address.
//   cpu_rd_addr_i : CPU address.
//   scan_win_o    : scanner owns the port this cycle.
//   cpu_rd_gnt_o  : CPU owns the port this cycle.
//   rf_raddr_o    : address to the RF read port.
// The CPU wins by default; after MAX_STARVE consecutive CPU-won cycles a pending
// scanner request takes one cycle.
module rf_port_arb #(
    parameter int          AW         = 5,
    parameter int unsigned MAX_STARVE = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          scan_req_i,
    input  logic          capture_i,
    input  logic          cpu_rd_req_i,
    input  logic [AW-1:0] scan_addr_i,
    input  logic [AW-1:0] cpu_rd_addr_i,
    output logic          scan_win_o,
    output logic          cpu_rd_gnt_o,
    output logic [AW-1:0] rf_raddr_o
);
    localparam logic [3:0] STARVE_MAX = 4'(MAX_STARVE);

    logic [3:0] starve_q, starve_d;

    always_comb begin
        scan_win_o   = scan_req_i && (!cpu_rd_req_i || (starve_q == STARVE_MAX));
        cpu_rd_gnt_o = cpu_rd_req_i && !scan_win_o;
        rf_raddr_o   = scan_win_o ? scan_addr_i : cpu_rd_addr_i;
    end

    // Counts CPU-won cycles while the scanner waits. An abandoned request
    // (scan_en dropped) leaves a stale count for one IDLE cycle; it is cleared
    // there, well before REQ can be re-entered through WAIT.
    always_comb begin
        starve_d = starve_q;
        if (!scan_req_i || capture_i) begin
            starve_d = 4'd0;
        end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
endmodule

// File: rtl/rf_scan_ctrl.sv
// rf_scan_ctrl: steps a scan address through the register file, one register per
// step tick, capturing each value for the debug display, while sharing the RF
// read port with the CPU.
//   clk, rstn  : clock, synchronous active-low reset.
//   step_tick  : one-cycle advance pulse.
//   scan_en    : scanning enabled.
//   hold       : ticks ignored while high.
//   load_en    : load load_addr into the scan address (any state).
//   load_addr  : address to load.
//   rd         : CPU request / RF read port bundle (slave side).
//   disp_data  : last captured register value.
//   disp_addr  : address of disp_data.
//   disp_valid : one-cycle pulse when disp_data updates.
//   busy       : high while a scan read is pending (REQ).
//   dbg_state  : current sequencer state.
module rf_scan_ctrl
    import rf_scan_pkg::*;
#(
    parameter int          AW         = AW_DEF,
    parameter int          DW         = DW_DEF,
    parameter bit          SKIP_ZERO  = 1'b1,
    parameter int unsigned MAX_STARVE = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          step_tick,
    input  logic          scan_en,
    input  logic          hold,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    rf_scan_ctrl_if.slave rd,
    output logic [DW-1:0] disp_data,
    output logic [AW-1:0] disp_addr,
    output logic          disp_valid,
    output logic          busy,
    output state_e        dbg_state
);
    localparam logic [AW-1:0] ADDR_FIRST = AW'(addr_first(SKIP_ZERO));
    localparam logic [AW-1:0] ADDR_LAST  = '1;

    state_e        state_q, state_d;
    logic [AW-1:0] scan_addr_q, scan_addr_d;
    logic [DW-1:0] disp_data_q, disp_data_d;
    logic [AW-1:0] disp_addr_q, disp_addr_d;
    logic          disp_valid_q, disp_valid_d;
    logic          scan_req, scan_win, capture;

    assign scan_req = (state_q == ST_REQ);
    // Winning the port only captures if scanning is still enabled; a drop of
    // scan_en in REQ abandons the read.
    assign capture  = scan_win && scan_en;

    rf_port_arb #(
        .AW         (AW),
        .MAX_STARVE (MAX_STARVE)
    ) u_arb (
        .clk           (clk),
        .rstn          (rstn),
        .scan_req_i    (scan_req),
        .capture_i     (capture),
        .cpu_rd_req_i  (rd.cpu_rd_req),
        .scan_addr_i   (scan_addr_q),
        .cpu_rd_addr_i (rd.cpu_rd_addr),
        .scan_win_o    (scan_win),
        .cpu_rd_gnt_o  (rd.cpu_rd_gnt),
        .rf_raddr_o    (rd.rf_raddr)
    );

    always_comb begin
        state_d      = state_q;
        scan_addr_d  = scan_addr_q;
        disp_data_d  = disp_data_q;
        disp_addr_d  = disp_addr_q;
        disp_valid_d = capture;

        case (state_q)
            ST_IDLE: if (scan_en) state_d = ST_WAIT;
            ST_WAIT: begin
                if (!scan_en)                 state_d = ST_IDLE;
                else if (step_tick && !hold)  state_d = ST_REQ;
            end
            ST_REQ: begin
                if (!scan_en)      state_d = ST_IDLE;
                else if (scan_win) state_d = ST_WAIT;
            end
            default: state_d = ST_IDLE;
        endcase

        if (capture) begin
            disp_data_d = rd.rf_rdata;
            disp_addr_d = scan_addr_q;
            scan_addr_d = (scan_addr_q == ADDR_LAST) ? ADDR_FIRST : scan_addr_q + 1'b1;
        end

        // Load overrides the capture increment; ADDR_FIRST is 1 only when x0 is skipped.
        if (load_en) begin
            scan_addr_d = (load_addr == '0) ? ADDR_FIRST : load_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            scan_addr_q  <= ADDR_FIRST;
            disp_data_q  <= '0;
            disp_addr_q  <= '0;
            disp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            scan_addr_q  <= scan_addr_d;
            disp_data_q  <= disp_data_d;
            disp_addr_q  <= disp_addr_d;
            disp_valid_q <= disp_valid_d;
        end
    end

    assign disp_data  = disp_data_q;
    assign disp_addr  = disp_addr_q;
    assign disp_valid = disp_valid_q;
    assign busy       = scan_req;
    assign dbg_state  = state_q;
endmodule

// File: tb/tb_rf_scan_ctrl.sv
// Bench for rf_scan_ctrl: two instances (x0 skipped / not skipped) share all
// stimulus; each has its own RF image reg[i] = i*0x11.
module tb_rf_scan_ctrl;
    import rf_scan_pkg::*;

    localparam int MAX_STARVE = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn = 1'b0;
    logic       step_tick = 1'b0, scan_en = 1'b0, hold = 1'b0, load_en = 1'b0;
    logic [4:0] load_addr = '0;
    logic       cpu_rd_req = 1'b0;
    logic [4:0] cpu_rd_addr = '0;

    logic [31:0] mem [32];
    initial for (int i = 0; i < 32; i++) mem[i] = 32'(i * 'h11);

    rf_scan_ctrl_if #(.AW(5), .DW(32)) bus0 ();
    rf_scan_ctrl_if #(.AW(5), .DW(32)) bus1 ();

    assign bus0.cpu_rd_req  = cpu_rd_req;
    assign bus0.cpu_rd_addr = cpu_rd_addr;
    assign bus0.rf_rdata    = mem[bus0.rf_raddr];
    assign bus1.cpu_rd_req  = cpu_rd_req;
    assign bus1.cpu_rd_addr = cpu_rd_addr;
    assign bus1.rf_rdata    = mem[bus1.rf_raddr];

    logic [1:0]       a_dv, a_busy, a_gnt;
    logic [1:0][4:0]  a_da, a_ra;
    logic [1:0][31:0] a_dd;
    state_e           st0, st1;

    assign a_gnt[0] = bus0.cpu_rd_gnt;
    assign a_gnt[1] = bus1.cpu_rd_gnt;
    assign a_ra[0]  = bus0.rf_raddr;
    assign a_ra[1]  = bus1.rf_raddr;

    rf_scan_ctrl #(.AW(5), .DW(32), .SKIP_ZERO(1'b0), .MAX_STARVE(MAX_STARVE)) u0 (
        .clk(clk), .rstn(rstn), .step_tick(step_tick), .scan_en(scan_en), .hold(hold),
        .load_en(load_en), .load_addr(load_addr), .rd(bus0.slave),
        .disp_data(a_dd[0]), .disp_addr(a_da[0]), .disp_valid(a_dv[0]), .busy(a_busy[0]),
        .dbg_state(st0)
    );

    rf_scan_ctrl #(.AW(5), .DW(32), .SKIP_ZERO(1'b1), .MAX_STARVE(MAX_STARVE)) u1 (
        .clk(clk), .rstn(rstn), .step_tick(step_tick), .scan_en(scan_en), .hold(hold),
        .load_en(load_en), .load_addr(load_addr), .rd(bus1.slave),
        .disp_data(a_dd[1]), .disp_addr(a_da[1]), .disp_valid(a_dv[1]), .busy(a_busy[1]),
        .dbg_state(st1)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[u%0d] @%0t got %0h want %0h", nm, k, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // active: scanning session running; pending: a scan read is outstanding.
    typedef struct {
        bit          active;
        bit          pending;
        int          starve;
        int          addr;
        int          da;
        logic [31:0] dd;
        bit          dv;
    } mdl_t;
    mdl_t m [2];

    function automatic int first_of(input int k);
        return (k == 1) ? 1 : 0;
    endfunction

    function automatic bit m_win(input int k);
        return m[k].pending && (!cpu_rd_req || m[k].starve == MAX_STARVE);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m[k].active = 0; m[k].pending = 0; m[k].starve = 0;
            m[k].addr = first_of(k); m[k].da = 0; m[k].dd = '0; m[k].dv = 0;
        end
    endtask

    task automatic model_check();
        for (int k = 0; k < 2; k++) begin
            bit w;
            w = m_win(k);
            chk("gnt",  k, 32'(a_gnt[k]),  32'(cpu_rd_req && !w));
            chk("addr", k, 32'(a_ra[k]),   w ? 32'(m[k].addr) : 32'(cpu_rd_addr));
            chk("busy", k, 32'(a_busy[k]), 32'(m[k].pending));
            chk("dv",   k, 32'(a_dv[k]),   32'(m[k].dv));
            chk("da",   k, 32'(a_da[k]),   32'(m[k].da));
            chk("dd",   k, a_dd[k],        m[k].dd);
        end
    endtask

    task automatic model_update();
        if (!rstn) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            bit w, cap;
            int nxt;
            w   = m_win(k);
            cap = w && scan_en;
            nxt = m[k].addr;
            m[k].dv = cap;
            if (cap) begin
                m[k].dd = mem[m[k].addr];
                m[k].da = m[k].addr;
                nxt = (m[k].addr == 31) ? first_of(k) : m[k].addr + 1;
            end
            if (load_en) nxt = (load_addr == 0 && k == 1) ? 1 : int'(load_addr);
            if (!m[k].active) begin
                m[k].active = scan_en; m[k].pending = 0; m[k].starve = 0;
            end else if (m[k].pending) begin
                if (!scan_en) begin
                    m[k].active = 0; m[k].pending = 0; m[k].starve = 0;
                end else if (w) begin
                    m[k].pending = 0; m[k].starve = 0;
                end else if (m[k].starve < MAX_STARVE) begin
                    m[k].starve++;
                end
            end else begin
                if (!scan_en) m[k].active = 0;
                else if (step_tick && !hold) m[k].pending = 1;
                m[k].starve = 0;
            end
            m[k].addr = nxt;
        end
    endtask

    // One clock: compare at negedge, advance model at posedge, return at posedge+1.
    task automatic step();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        bit          en, tk, hd, req;
        logic [4:0]  ca;
        bit          e_gnt, e_busy, e_dv;
        logic [4:0]  e_ra, e_da;
        logic [31:0] e_dd;
    } vec_t;
    vec_t tbl [18];

    function automatic vec_t mk(input int en, input int tk, input int hd, input int req, input int ca,
                                input int g, input int b, input int dv, input int ra, input int da, input int dd);
        vec_t v;
        v.en = en[0]; v.tk = tk[0]; v.hd = hd[0]; v.req = req[0]; v.ca = 5'(ca);
        v.e_gnt = g[0]; v.e_busy = b[0]; v.e_dv = dv[0];
        v.e_ra = 5'(ra); v.e_da = 5'(da); v.e_dd = 32'(dd);
        return v;
    endfunction

    task automatic wait_capture(input string nm);
        bit got;
        got = 0;
        for (int w = 0; w < 6 && !got; w++) begin
            step();
            if (a_dv[1] === 1'b1) got = 1;
        end
        chk(nm, 1, 32'(got), 32'd1);
    endtask

    task automatic do_tick();
        step_tick = 1'b1;
        step();
        step_tick = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        //  en tk hd rq ca   gnt busy dv ra da dd
        tbl[0]  = mk(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 0, 0,  0, 1, 0, 1, 0, 0);
        tbl[3]  = mk(1, 0, 0, 0, 0,  0, 0, 1, 0, 1, 'h11);
        tbl[4]  = mk(1, 1, 0, 0, 0,  0, 0, 0, 0, 1, 'h11);
        tbl[5]  = mk(1, 0, 0, 0, 0,  0, 1, 0, 2, 1, 'h11);
        tbl[6]  = mk(1, 0, 0, 0, 0,  0, 0, 1, 0, 2, 'h22);
        tbl[7]  = mk(1, 1, 0, 1, 7,  1, 0, 0, 7, 2, 'h22);
        tbl[8]  = mk(1, 0, 0, 1, 7,  1, 1, 0, 7, 2, 'h22);
        tbl[9]  = mk(1, 0, 0, 1, 7,  1, 1, 0, 7, 2, 'h22);
        tbl[10] = mk(1, 0, 0, 1, 7,  1, 1, 0, 7, 2, 'h22);
        tbl[11] = mk(1, 0, 0, 1, 7,  1, 1, 0, 7, 2, 'h22);
        tbl[12] = mk(1, 0, 0, 1, 7,  0, 1, 0, 3, 2, 'h22);
        tbl[13] = mk(1, 0, 0, 1, 7,  1, 0, 1, 7, 3, 'h33);
        tbl[14] = mk(1, 0, 0, 1, 7,  1, 0, 0, 7, 3, 'h33);
        tbl[15] = mk(1, 1, 1, 0, 7,  0, 0, 0, 7, 3, 'h33);
        tbl[16] = mk(1, 0, 0, 0, 7,  0, 0, 0, 7, 3, 'h33);
        tbl[17] = mk(1, 0, 0, 0, 7,  0, 0, 0, 7, 3, 'h33);

        // reset: registers are unknown until the first reset edge
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        step();
        rstn = 1'b1;
        chk("rst_dv",   1, 32'(a_dv[1]),   32'd0);
        chk("rst_dd",   1, a_dd[1],        32'd0);
        chk("rst_da",   1, 32'(a_da[1]),   32'd0);
        chk("rst_busy", 1, 32'(a_busy[1]), 32'd0);

        // table: latency, second tick, starvation, hold
        for (int i = 0; i < 18; i++) begin
            scan_en = tbl[i].en; step_tick = tbl[i].tk; hold = tbl[i].hd;
            cpu_rd_req = tbl[i].req; cpu_rd_addr = tbl[i].ca;
            #2;
            chk($sformatf("tbl%0d_gnt", i),  1, 32'(a_gnt[1]),  32'(tbl[i].e_gnt));
            chk($sformatf("tbl%0d_ra", i),   1, 32'(a_ra[1]),   32'(tbl[i].e_ra));
            chk($sformatf("tbl%0d_busy", i), 1, 32'(a_busy[1]), 32'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_dv", i),   1, 32'(a_dv[1]),   32'(tbl[i].e_dv));
            chk($sformatf("tbl%0d_da", i),   1, 32'(a_da[1]),   32'(tbl[i].e_da));
            chk($sformatf("tbl%0d_dd", i),   1, a_dd[1],        tbl[i].e_dd);
            step();
        end
        step_tick = 1'b0; hold = 1'b0;

        // scan_en dropped in REQ under contention: abandoned, address kept
        cpu_rd_req = 1'b1;
        do_tick();
        step(); step();
        scan_en = 1'b0;
        step();
        chk("abort_busy", 1, 32'(a_busy[1]), 32'd0);
        chk("abort_dv",   1, 32'(a_dv[1]),   32'd0);
        chk("abort_dd",   1, a_dd[1],        32'h33);
        scan_en = 1'b1; cpu_rd_req = 1'b0;
        step();
        do_tick();
        wait_capture("abort_cap");
        chk("abort_next_da", 1, 32'(a_da[1]), 32'd4);
        chk("abort_next_dd", 1, a_dd[1],      32'h44);

        // load 20 in WAIT
        load_en = 1'b1; load_addr = 5'd20;
        step();
        load_en = 1'b0;
        do_tick();
        wait_capture("load20_cap");
        chk("load20_da", 1, 32'(a_da[1]), 32'd20);
        chk("load20_dd", 1, a_dd[1],      32'h154);

        // load 0 with x0 skipped -> 1
        load_en = 1'b1; load_addr = 5'd0;
        step();
        load_en = 1'b0;
        do_tick();
        wait_capture("load0_cap");
        chk("load0_da", 1, 32'(a_da[1]), 32'd1);
        chk("load0_dd", 1, a_dd[1],      32'h11);

        // load on the capture cycle
        do_tick();
        load_en = 1'b1; load_addr = 5'd10;
        step();
        load_en = 1'b0;
        chk("ldcap_da", 1, 32'(a_da[1]), 32'd2);
        chk("ldcap_dd", 1, a_dd[1],      32'h22);
        do_tick();
        wait_capture("ldcap_next");
        chk("ldcap_next_da", 1, 32'(a_da[1]), 32'd10);
        chk("ldcap_next_dd", 1, a_dd[1],      32'hAA);

        // reset in REQ
        cpu_rd_req = 1'b1;
        do_tick();
        step();
        chk("rreq_busy_pre", 1, 32'(a_busy[1]), 32'd1);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        chk("rreq_busy", 1, 32'(a_busy[1]), 32'd0);
        chk("rreq_dv",   1, 32'(a_dv[1]),   32'd0);
        chk("rreq_dd",   1, a_dd[1],        32'd0);
        cpu_rd_req = 1'b0;
        step();
        do_tick();
        wait_capture("rreq_cap");
        chk("rreq_next_da", 1, 32'(a_da[1]), 32'd1);

        // wrap: 33 ticks from reset on both instances
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        step();
        for (int i = 0; i < 33; i++) begin
            do_tick();
            wait_capture("wrap_cap");
            chk("wrap_da1", 1, 32'(a_da[1]), 32'((i % 31) + 1));
            chk("wrap_da0", 0, 32'(a_da[0]), 32'(i % 32));
        end

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            rstn        = ($urandom_range(0, 99) != 0);
            scan_en     = ($urandom_range(0, 19) != 0);
            step_tick   = ($urandom_range(0, 2) == 0);
            hold        = ($urandom_range(0, 4) == 0);
            load_en     = ($urandom_range(0, 24) == 0);
            load_addr   = 5'($urandom_range(0, 31));
            cpu_rd_req  = ($urandom_range(0, 1) == 1);
            cpu_rd_addr = 5'($urandom_range(0, 31));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
